// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: memory-to-writeback pipeline register for the pipelined MIPS core.
// It carries valE/valM and their destination indices through DEPTH register
// stages. The stages can be held (W_stall) or have a NOP loaded into stage 0
// (W_bubble). It also counts the instructions that leave W.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   M_valE, m_valM                ALU result / memory read data from M
//   M_dstE, M_dstM                destination indices for valE / valM
//   M_valid                       M holds a real instruction
//   W_stall, W_bubble             hold all stages / load NOP into stage 0
//   W_valE, W_valM                registered data (last stage)
//   W_dstE, W_dstM                registered destinations
//   W_valid                       last stage holds a real instruction
//   W_weE, W_weM                  register-file write enables
//   W_retired                     count of instructions leaving W (wraps)
module wb_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 1,
  parameter int NONE_REG = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [REG_W-1:0]  M_dstE,
  input  logic [REG_W-1:0]  M_dstM,
  input  logic              M_valid,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [REG_W-1:0]  W_dstE,
  output logic [REG_W-1:0]  W_dstM,
  output logic              W_valid,
  output logic              W_weE,
  output logic              W_weM,
  output logic [CNT_W-1:0]  W_retired
);

  localparam logic [REG_W-1:0] NONE_IDX = REG_W'(NONE_REG);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_m;
    logic [REG_W-1:0]  dst_e;
    logic [REG_W-1:0]  dst_m;
    logic              we_e;
    logic              we_m;
  } slot_t;

  localparam slot_t NOP_SLOT = '{
    valid: 1'b0,
    val_e: '0,
    val_m: '0,
    dst_e: NONE_IDX,
    dst_m: NONE_IDX,
    we_e:  1'b0,
    we_m:  1'b0
  };

  slot_t            slot_q [DEPTH];
  slot_t            m_slot;
  logic             we_m;
  logic             we_e;
  logic [CNT_W-1:0] retired_q;

  // Enables are resolved once, on entry. When both ports target the same
  // register, the M port (load data) wins and the E write is suppressed.
  always_comb begin
    we_m = M_valid && (M_dstM != NONE_IDX);
    we_e = M_valid && (M_dstE != NONE_IDX) && !(we_m && (M_dstE == M_dstM));

    m_slot.valid = M_valid;
    m_slot.val_e = M_valE;
    m_slot.val_m = m_valM;
    m_slot.dst_e = M_dstE;
    m_slot.dst_m = M_dstM;
    m_slot.we_e  = we_e;
    m_slot.we_m  = we_m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= NOP_SLOT;
      end
      retired_q <= '0;
    end else if (!W_stall) begin
      // A bubble clears only stage 0. Older stages keep advancing.
      slot_q[0] <= W_bubble ? NOP_SLOT : m_slot;
      for (int k = 1; k < DEPTH; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
      // An instruction retires when it shifts out of the last stage.
      if (slot_q[DEPTH-1].valid) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign W_valid   = slot_q[DEPTH-1].valid;
  assign W_valE    = slot_q[DEPTH-1].val_e;
  assign W_valM    = slot_q[DEPTH-1].val_m;
  assign W_dstE    = slot_q[DEPTH-1].dst_e;
  assign W_dstM    = slot_q[DEPTH-1].dst_m;
  assign W_weE     = slot_q[DEPTH-1].we_e;
  assign W_weM     = slot_q[DEPTH-1].we_m;
  assign W_retired = retired_q;

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised memory-to-writeback pipeline register for the pipelined MIPS core. It carries the ALU result, the load data and both destination register indices from the M stage to the W stage. It supports a configurable number of register stages, stall (hold), bubble (NOP insertion), a valid bit, and conflict-resolved write enables. It also keeps a retired-instruction counter. With DEPTH=1 and no stall or bubble asserted, it behaves as the plain M→W register.

## Interface
Parameters:
- DATA_W, 32, width of valE/valM
- REG_W, 5, width of register indices
- DEPTH, 1, number of register stages from M inputs to W outputs (≥1)
- NONE_REG, 0, index meaning "no write"; also loaded into dst fields on bubble/reset
- CNT_W, 32, width of retired counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- M_valE  in  DATA_W  ALU result from M stage
- m_valM  in  DATA_W  memory read data
- M_dstE  in  REG_W  destination for valE
- M_dstM  in  REG_W  destination for valM
- M_valid  in  1  M stage holds a real instruction
- W_stall  in  1  hold all stages
- W_bubble  in  1  load NOP into stage 0
- W_valE  out  DATA_W  registered valE (last stage)
- W_valM  out  DATA_W  registered valM
- W_dstE  out  REG_W  registered dstE
- W_dstM  out  REG_W  registered dstM
- W_valid  out  1  last stage holds a real instruction
- W_weE  out  1  register-file write enable, E port
- W_weM  out  1  register-file write enable, M port
- W_retired  out  CNT_W  count of instructions leaving W

## Operation
- State: DEPTH stage slots. Each slot holds {valid, valE, valM, dstE, dstM, weE, weM}. Outputs are driven directly from slot DEPTH-1 (registered, no combinational path from inputs).
- NOP slot: valid=0, valE=0, valM=0, dstE=dstM=NONE_REG, weE=weM=0.
- Per-edge priority: rst > W_stall > W_bubble > normal load.
  - rst asserted: all slots become NOP and W_retired=0, immediately and independent of clk.
  - W_stall=1: every slot holds, the counter holds, and W_bubble is ignored.
  - W_bubble=1, W_stall=0: slots k≥1 take slot k-1 and slot 0 takes NOP. M inputs are discarded.
  - Normal: slots k≥1 take slot k-1 and slot 0 takes the M inputs.
- Enable computation, done on entry to slot 0 and carried unchanged through later slots:
  - weM = M_valid & (M_dstM != NONE_REG).
  - weE = M_valid & (M_dstE != NONE_REG) & ~(weM & M_dstE == M_dstM). On a same-register conflict, the M port wins.
- When M_valid=0 on a normal load, the data fields are loaded as presented, but valid, weE and weM are all 0.
- Retired counter: increments by 1 on each rising edge where W_valid=1 and W_stall=0, evaluated on the pre-edge values. It wraps modulo 2^CNT_W (all ones → 0).

## Timing
- Latency: DEPTH cycles from M inputs sampled at edge n to W outputs valid after edge n+DEPTH-1, provided there are no stalls. Each stalled edge adds one cycle.
- Reset values: every W_* output and W_weE/W_weM are 0 (W_dstE/W_dstM = NONE_REG), and W_retired=0.
- Reset deassertion mid-stream: the first rising edge with rst=0 performs a normal, bubble or stall update. No extra recovery cycle.
- Throughput: one instruction per cycle when not stalled.
- A stall held for N edges freezes the outputs for N edges. Outputs resume shifting on the first edge with W_stall=0.
- W_stall and W_bubble asserted together behave exactly as stall alone.
- DEPTH>1 with bubble: only slot 0 is cleared. Instructions already in later slots advance normally.

## Test plan
- Reset: assert rst asynchronously between edges with nonzero contents → all outputs 0 and W_retired=0 before the next edge. Deassert, then load valE=0x1234, dstE=3, valid → W_valE=0x1234, W_weE=1 after one edge (DEPTH=1).
- Stall/bubble: stream valE=1,2,3 and hold W_stall for 2 edges while 2 is in W → W_valE stays 2 for 3 cycles total, W_retired increments only when W_stall=0. Assert bubble and stall together → same as stall. Assert bubble alone → next W_valid=0, W_dstE=W_dstM=NONE_REG.
- Conflict: M_dstE=M_dstM=7, valid → W_weM=1, W_weE=0. With M_dstE=NONE_REG → W_weE=0. With M_valid=0 and dst=5 → both enables 0.
- DEPTH=3: inject valE=0xA at edge 0 → it appears at W after edge 2. A bubble at edge 1 yields one NOP slot between back-to-back instructions at the output.
- Counter wrap: CNT_W=4, retire 17 valid instructions → W_retired=1.
